// File: rtl/wb_spram_pkg.sv
// Shared types and helpers for the Wishbone single-port RAM adapter.
// Holds the adapter state enum and the byte-lane merge used by read-modify-write.
// The merge works on a fixed maximum width; callers zero-extend and truncate.
package wb_spram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

  // Widest data word the merge helper supports (data_width must not exceed it).
  localparam int MERGE_MAX_DW = 64;
  localparam int MERGE_MAX_SW = MERGE_MAX_DW / 8;

  // Byte i of the result comes from wr_dat when sel[i] is set, else from ram_dat.
  function automatic logic [MERGE_MAX_DW-1:0] merge_bytes(
    input logic [MERGE_MAX_DW-1:0] wr_dat,
    input logic [MERGE_MAX_DW-1:0] ram_dat,
    input logic [MERGE_MAX_SW-1:0] sel
  );
    logic [MERGE_MAX_DW-1:0] m;
    m = ram_dat;
    for (int i = 0; i < MERGE_MAX_SW; i++) begin
      if (sel[i]) m[8*i +: 8] = wr_dat[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_spram_port.sv
// Wishbone B4 pipelined slave in front of an external single-port RAM with a
// registered output. Reads and full/empty-select writes ack one cycle after
// acceptance at one per cycle; with WB_SPRAM_RMW_EN defined, partial-select
// writes become a read followed by a merged write (stall for one cycle, ack
// two cycles after acceptance). Without WB_SPRAM_RMW_EN any nonzero select is
// treated as a full-word write and stall is tied low.
// Ports: clock/reset, Wishbone slave (wb_*), RAM master (ram_*; ram_q in).
module wb_spram_port
  import wb_spram_pkg::*;
#(
  parameter int size       = 'h1000,
  parameter int addr_width = $clog2(size),
  parameter int data_width = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [addr_width-1:0]   wb_adr_i,
  input  logic [data_width-1:0]   wb_dat_i,
  input  logic [data_width/8-1:0] wb_sel_i,
  output logic [data_width-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_stall_o,
  output logic [addr_width-1:0]   ram_address,
  output logic [data_width-1:0]   ram_data,
  output logic                    ram_wren,
  output logic                    ram_cen,
  input  logic [data_width-1:0]   ram_q
);

  localparam int SW = data_width / 8;

  logic accept;
  logic wr_none;
  logic wr_part;
  logic in_merge;
  logic ack_q, ack_d;

`ifdef WB_SPRAM_RMW_EN
  state_e                state_q, state_d;
  logic [addr_width-1:0] adr_q, adr_d;
  logic [data_width-1:0] dat_q, dat_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [data_width-1:0] merged;

  assign in_merge = (state_q == MERGE);
  assign merged   = data_width'(merge_bytes(MERGE_MAX_DW'(dat_q),
                                            MERGE_MAX_DW'(ram_q),
                                            MERGE_MAX_SW'(sel_q)));
`else
  assign in_merge = 1'b0;
`endif

  // Reset gates acceptance so nothing reaches the RAM while it is held.
  assign accept = !reset && wb_cyc_i && wb_stb_i && !in_merge;
  assign wr_none = (wb_sel_i == '0);

`ifdef WB_SPRAM_RMW_EN
  assign wr_part = accept && wb_we_i && !wr_none && (wb_sel_i != '1);
`else
  assign wr_part = 1'b0;
`endif

  always_comb begin
    ram_address = wb_adr_i;
    ram_data    = wb_dat_i;
    ram_cen     = 1'b0;
    ram_wren    = 1'b0;
`ifdef WB_SPRAM_RMW_EN
    if (in_merge) begin
      // Second half of RMW: ram_q holds the word read in the previous cycle.
      ram_address = adr_q;
      ram_data    = merged;
      ram_cen     = 1'b1;
      ram_wren    = 1'b1;
    end else
`endif
    if (accept) begin
      if (!wb_we_i) begin
        ram_cen = 1'b1;
      end else if (wr_part) begin
        ram_cen = 1'b1;             // read the old word for merging
      end else if (!wr_none) begin
        ram_cen  = 1'b1;
        ram_wren = 1'b1;
      end
    end
  end

  // Merge completes even if the master abandons the cycle, but is only acked
  // when the cycle is still alive.
  assign ack_d = (accept && !wr_part) || (in_merge && wb_cyc_i);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ack_q <= 1'b0;
    else       ack_q <= ack_d;
  end

`ifdef WB_SPRAM_RMW_EN
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (wr_part) begin
          state_d = MERGE;
          adr_d   = wb_adr_i;
          dat_d   = wb_dat_i;
          sel_d   = wb_sel_i;
        end
      end
      MERGE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
    end
  end
`endif

  assign wb_ack_o   = ack_q && wb_cyc_i;
  assign wb_stall_o = in_merge;
  assign wb_dat_o   = ram_q;

endmodule

// File: tb/tb_wb_spram_port.sv
module tb_wb_spram_port;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int SW = 2;
`ifdef WB_SPRAM_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          wb_cyc_i, wb_stb_i, wb_we_i;
  logic [AW-1:0] wb_adr_i;
  logic [DW-1:0] wb_dat_i;
  logic [SW-1:0] wb_sel_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o, wb_stall_o;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data, ram_q;
  logic          ram_wren, ram_cen;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int passes = 0;
  int cen_cnt = 0;
  int ack_cnt = 0;
  int stall_cnt = 0;

  // Snapshot of RAM-side outputs in the cycle a request is accepted.
  logic          acc_cen, acc_wren, acc_stall;
  logic [AW-1:0] acc_adr;
  logic [DW-1:0] acc_data;

  always #5 clock = ~clock;

  wb_spram_port #(.size(1 << AW), .addr_width(AW), .data_width(DW)) dut (
    .clock(clock), .reset(reset),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_cen(ram_cen), .ram_q(ram_q)
  );

  // Single-port RAM with registered output (read-before-write on q).
  always @(posedge clock) begin
    if (ram_cen) begin
      if (ram_wren) mem[ram_address] <= ram_data;
      ram_q <= mem[ram_address];
    end
  end

  always @(negedge clock) begin
    if (ram_cen === 1'b1) cen_cnt++;
    if (wb_ack_o === 1'b1) ack_cnt++;
    if (wb_stall_o === 1'b1) stall_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: effect of a write on a stored word, from the select rules.
  function automatic logic [DW-1:0] ref_write(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                              input logic [SW-1:0] sel);
    logic [DW-1:0] mask;
    mask = {{8{sel[1]}}, {8{sel[0]}}};
    if (sel == 2'b00) return old;
    if (!RMW) return wd;
    return (old & ~mask) | (wd & mask);
  endfunction

  function automatic int ref_lat(input bit we, input logic [SW-1:0] sel);
    if (RMW && we && sel != 2'b00 && sel != 2'b11) return 2;
    return 1;
  endfunction

  // One complete transaction; entered and left at posedge+1.
  task automatic xact(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                      input logic [SW-1:0] sel, output logic [DW-1:0] rd, output int lat);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    @(negedge clock);
    acc_cen = ram_cen; acc_wren = ram_wren; acc_stall = wb_stall_o;
    acc_adr = ram_address; acc_data = ram_data;
    @(posedge clock); #1;
    wb_stb_i = 1'b0;
    lat = 0;
    rd = '0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      if (wb_ack_o) begin
        lat = i;
        rd = wb_dat_o;
        break;
      end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    @(negedge clock);
    check("single_ack", {31'd0, wb_ack_o}, 32'd0);
    @(posedge clock); #1;
    wb_cyc_i = 1'b0;
  endtask

  typedef struct {
    bit            we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic [DW-1:0] exp_rd;
  } vec_t;

  logic [DW-1:0] model [0:15];

  initial begin
    vec_t vt [12];
    logic [DW-1:0] rd;
    int lat;
    int c0, a0;

    vt[0]  = '{1'b1, 12'h100, 16'hBEEF, 2'b11, 16'h0000};
    vt[1]  = '{1'b1, 12'h101, 16'h0F0F, 2'b11, 16'h0000};
    vt[2]  = '{1'b0, 12'h100, 16'h0000, 2'b11, 16'hBEEF};
    vt[3]  = '{1'b0, 12'h101, 16'h0000, 2'b11, 16'h0F0F};
    vt[4]  = '{1'b1, 12'h100, 16'h1122, 2'b10, 16'h0000};
    vt[5]  = '{1'b0, 12'h100, 16'h0000, 2'b11, RMW ? 16'h11EF : 16'h1122};
    vt[6]  = '{1'b1, 12'h101, 16'hAA55, 2'b01, 16'h0000};
    vt[7]  = '{1'b0, 12'h101, 16'h0000, 2'b00, RMW ? 16'h0F55 : 16'hAA55};
    vt[8]  = '{1'b1, 12'hFFF, 16'h7E7E, 2'b11, 16'h0000};
    vt[9]  = '{1'b1, 12'h000, 16'h8001, 2'b11, 16'h0000};
    vt[10] = '{1'b0, 12'hFFF, 16'h0000, 2'b11, 16'h7E7E};
    vt[11] = '{1'b0, 12'h000, 16'h0000, 2'b11, 16'h8001};

    // Reset with a request presented: RAM must stay idle.
    reset = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 2'b11;
    repeat (2) @(negedge clock);
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_stall", {31'd0, wb_stall_o}, 32'd0);
    check("rst_cen", {31'd0, ram_cen}, 32'd0);
    check("rst_wren", {31'd0, ram_wren}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clock); #1;
    stall_cnt = 0;

    // Full write then read of 0x010.
    xact(1'b1, 12'h010, 16'h1234, 2'b11, rd, lat);
    check("w010_lat", lat, 1);
    check("w010_cen", {31'd0, acc_cen}, 1);
    check("w010_wren", {31'd0, acc_wren}, 1);
    check("w010_data", {16'd0, acc_data}, 32'h1234);
    check("w010_adr", {20'd0, acc_adr}, 32'h010);
    xact(1'b0, 12'h010, 16'h0000, 2'b11, rd, lat);
    check("r010_lat", lat, 1);
    check("r010_dat", {16'd0, rd}, 32'h1234);
    check("r010_wren", {31'd0, acc_wren}, 0);
    check("r010_stall", stall_cnt, 0);

    // Table vectors.
    for (int i = 0; i < 12; i++) begin
      xact(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, rd, lat);
      check($sformatf("vec%0d_lat", i), lat, ref_lat(vt[i].we, vt[i].sel));
      check($sformatf("vec%0d_adr", i), {20'd0, acc_adr}, {20'd0, vt[i].adr});
      check($sformatf("vec%0d_cen", i), {31'd0, acc_cen},
            (vt[i].we && vt[i].sel == 2'b00) ? 0 : 1);
      check($sformatf("vec%0d_wren", i), {31'd0, acc_wren},
            (vt[i].we && (vt[i].sel == 2'b11 || (!RMW && vt[i].sel != 2'b00))) ? 1 : 0);
      if (!vt[i].we) check($sformatf("vec%0d_rd", i), {16'd0, rd}, {16'd0, vt[i].exp_rd});
    end

    // Four back-to-back reads.
    for (int k = 0; k < 4; k++) xact(1'b1, AW'(k), DW'(16'hA000 + k), 2'b11, rd, lat);
    wb_cyc_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 2'b11;
    for (int k = 0; k < 5; k++) begin
      wb_stb_i = (k < 4);
      wb_adr_i = AW'(k < 4 ? k : 0);
      @(negedge clock);
      if (k < 4) check("b2b_stall", {31'd0, wb_stall_o}, 0);
      if (k > 0) begin
        check("b2b_ack", {31'd0, wb_ack_o}, 1);
        check("b2b_dat", {16'd0, wb_dat_o}, 32'hA000 + k - 1);
      end
      @(posedge clock); #1;
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;

    // Zero-select write leaves memory untouched and never enables the RAM.
    xact(1'b1, 12'h030, 16'h5555, 2'b11, rd, lat);
    c0 = cen_cnt;
    xact(1'b1, 12'h030, 16'h0000, 2'b00, rd, lat);
    check("sel0_lat", lat, 1);
    check("sel0_cen", cen_cnt - c0, 0);
    xact(1'b0, 12'h030, 16'h0000, 2'b11, rd, lat);
    check("sel0_content", {16'd0, rd}, 32'h5555);

    // Read accepted, then cycle dropped: no ack.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 12'h010;
    @(negedge clock);
    @(posedge clock); #1;
    a0 = ack_cnt;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (3) @(negedge clock);
    check("cyc_drop_ack", ack_cnt - a0, 0);
    @(posedge clock); #1;

`ifdef WB_SPRAM_RMW_EN
    // Partial write sequence, cycle by cycle.
    xact(1'b1, 12'h020, 16'hABCD, 2'b11, rd, lat);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 12'h020; wb_dat_i = 16'h1234; wb_sel_i = 2'b01;
    @(negedge clock);
    check("rmw_rd_cen", {31'd0, ram_cen}, 1);
    check("rmw_rd_wren", {31'd0, ram_wren}, 0);
    @(posedge clock); #1;
    wb_stb_i = 1'b0; wb_adr_i = 12'h0AA; wb_dat_i = 16'hFFFF;
    @(negedge clock);
    check("rmw_stall", {31'd0, wb_stall_o}, 1);
    check("rmw_wr_wren", {31'd0, ram_wren}, 1);
    check("rmw_wr_adr", {20'd0, ram_address}, 32'h020);
    check("rmw_wr_data", {16'd0, ram_data}, 32'hAB34);
    check("rmw_early_ack", {31'd0, wb_ack_o}, 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("rmw_ack", {31'd0, wb_ack_o}, 1);
    check("rmw_unstall", {31'd0, wb_stall_o}, 0);
    @(posedge clock); #1;
    wb_cyc_i = 1'b0;
    xact(1'b0, 12'h020, 16'h0000, 2'b11, rd, lat);
    check("rmw_readback", {16'd0, rd}, 32'hAB34);

    // Reset in the merge cycle: no write, no ack.
    xact(1'b1, 12'h020, 16'hABCD, 2'b11, rd, lat);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 12'h020; wb_dat_i = 16'h1234; wb_sel_i = 2'b01;
    @(posedge clock); #1;
    wb_stb_i = 1'b0;
    a0 = ack_cnt;
    reset = 1'b1;
    @(negedge clock);
    check("mrst_cen", {31'd0, ram_cen}, 0);
    check("mrst_stall", {31'd0, wb_stall_o}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("mrst_ack", ack_cnt - a0, 0);
    @(posedge clock); #1;
    wb_cyc_i = 1'b0;
    xact(1'b0, 12'h020, 16'h0000, 2'b11, rd, lat);
    check("mrst_content", {16'd0, rd}, 32'hABCD);

    // Cycle dropped during merge: write still lands, no ack.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 12'h020; wb_dat_i = 16'h9900; wb_sel_i = 2'b10;
    @(posedge clock); #1;
    a0 = ack_cnt;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (3) @(negedge clock);
    check("mdrop_ack", ack_cnt - a0, 0);
    @(posedge clock); #1;
    xact(1'b0, 12'h020, 16'h0000, 2'b11, rd, lat);
    check("mdrop_content", {16'd0, rd}, 32'h99CD);
`endif

    // Randomized traffic against the reference model over a 16-word window.
    for (int k = 0; k < 16; k++) begin
      model[k] = DW'($urandom);
      xact(1'b1, AW'(12'h200 + k), model[k], 2'b11, rd, lat);
    end
    for (int n = 0; n < 200; n++) begin
      bit            we;
      int            idx;
      logic [DW-1:0] wd;
      logic [SW-1:0] sel;
      we  = bit'($urandom_range(0, 1));
      idx = $urandom_range(0, 15);
      wd  = DW'($urandom);
      sel = SW'($urandom_range(0, 3));
      xact(we, AW'(12'h200 + idx), wd, sel, rd, lat);
      check($sformatf("rnd%0d_lat", n), lat, ref_lat(we, sel));
      if (we) model[idx] = ref_write(model[idx], wd, sel);
      else check($sformatf("rnd%0d_rd", n), {16'd0, rd}, {16'd0, model[idx]});
    end
    for (int k = 0; k < 16; k++) begin
      xact(1'b0, AW'(12'h200 + k), 16'h0000, 2'b11, rd, lat);
      check($sformatf("final%0d", k), {16'd0, rd}, {16'd0, model[k]});
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wb_spram_port.md
WB_SPRAM_PORT -- requirements
Module: wb_spram_port

Interface
REQ-001 Parameter: size, 'h1000, RAM depth in words.
REQ-002 Parameter: addr_width, $clog2(size), word-address width.
REQ-003 Parameter: data_width, 16, word width; SHALL be a multiple of 8.
REQ-004 Port: clock  in  1  single clock; all logic on its rising edge.
REQ-005 Port: reset  in  1  reset, asynchronous and active-high.
REQ-006 Ports: wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone B4 pipelined cycle, strobe and write-enable.
REQ-007 Ports: wb_adr_i  in  addr_width  word address; wb_dat_i  in  data_width  write data; wb_sel_i  in  data_width/8  byte selects.
REQ-008 Ports: wb_dat_o  out  data_width  read data; wb_ack_o  out  1  acknowledge; wb_stall_o  out  1  stall.
REQ-009 Ports: ram_address  out  addr_width; ram_data  out  data_width; ram_wren  out  1; ram_cen  out  1; ram_q  in  data_width.
REQ-010 RAM ports SHALL connect to a single-port RAM with registered output: data readable one cycle after cen, write when cen and wren.

Function
REQ-011 Request accepted in cycle N iff wb_cyc_i & wb_stb_i & !wb_stall_o.
REQ-012 Read accepted in N: ram_cen=1, ram_wren=0, ram_address=wb_adr_i combinationally in N; wb_ack_o=1 in N+1 with wb_dat_o=ram_q.
REQ-013 Back-to-back reads SHALL sustain one per cycle with wb_stall_o=0.
REQ-014 Full write (all wb_sel_i bits 1) accepted in N: ram_cen=ram_wren=1, ram_data=wb_dat_i in N; ack in N+1; no stall.
REQ-015 Write with wb_sel_i=0: no RAM access (ram_cen=0); ack in N+1.
REQ-016 State machine: IDLE, MERGE; wb_stall_o = (state==MERGE).
REQ-017 Partial write (WB_SPRAM_RMW_EN defined) in N: RAM read issued, address/data/sel latched, IDLE->MERGE.
REQ-018 MERGE (cycle N+1): ram_cen=ram_wren=1 at latched address, ram_data byte i = sel[i] ? latched byte i : ram_q byte i; MERGE->IDLE; ack in N+2.
REQ-019 New request SHALL be accepted in N+2 (stall low again).
REQ-020 wb_ack_o SHALL be 1 for exactly one cycle per accepted request, and suppressed if wb_cyc_i=0 in the ack cycle.
REQ-021 wb_cyc_i dropping during MERGE: merged write still completes (atomic); ack suppressed.
REQ-022 Address wrap: none; address used verbatim; behaviour for addresses >= size is the RAM's.
REQ-023 wb_dat_o SHALL equal ram_q in every cycle; valid only when wb_ack_o=1 after a read.
REQ-024 Outputs of ram_* SHALL be 0 (cen, wren) in any cycle with no accepted request and not in MERGE.

Reset
REQ-025 Reset asserted: state=IDLE, wb_ack_o=0, latched address/data/sel=0, immediately (asynchronous).
REQ-026 Reset during MERGE: merged write SHALL NOT be issued; no ack after release.
REQ-027 While reset asserted: ram_cen=0, ram_wren=0, wb_stall_o=0.

Configuration
REQ-028 Macro WB_SPRAM_RMW_EN defined: partial writes via read-modify-write per REQ-017..018.
REQ-029 Macro undefined: MERGE state absent, wb_stall_o tied 0; any write with nonzero wb_sel_i is a full-word write of wb_dat_i (sel ignored except all-zero per REQ-015), ack in N+1.

Structure
REQ-030 Shared package wb_spram_pkg SHALL hold the state enum (IDLE, MERGE) and the byte-merge function (data, ram word, sel -> merged word).
REQ-031 No sub-module; RAM instantiated by the parent, not inside this block.

Verification
REQ-032 Write 0x1234 to adr 0x010 (sel=2'b11), read adr 0x010 -> ack N+1 each, read data 0x1234, stall never high.
REQ-033 Four back-to-back reads adr 0..3 preloaded 0xA000..0xA003 -> four consecutive acks, data 0xA000..0xA003 in order.
REQ-034 RMW_EN: adr 0x020 holds 0xABCD, write 0x1234 sel=2'b01 -> stall high one cycle, ack N+2, read returns 0xAB34.
REQ-035 RMW_EN: reset pulse in MERGE of REQ-034 -> adr 0x020 still 0xABCD, no ack, state IDLE.
REQ-036 Write sel=2'b00 to adr 0x030 holding 0x5555 -> ack N+1, ram_cen never high, content 0x5555.
REQ-037 Read accepted, wb_cyc_i dropped next cycle -> wb_ack_o stays 0.
